led_flow_seq: RTL and testbench
===============================

Name: led_flow_seq

Overview:
- Downstream consumer of the periodic tick counter. Each 1-cycle `tick` pulse advances a multi-LED pattern by one step.
- Runtime-selectable pattern modes: rotate-left, rotate-right, ping-pong, blink-all. Includes pause and a pattern-period-complete strobe.
- Sits between the tick counter (CNT_MAX-based divider, 1-cycle flag output) and the board LED pins.

Parameters:
- LED_W, 4, number of LEDs driven; legal range 2..16.
- MODE_RST, 2'd0, mode loaded at reset.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  reset; synchronous, active-high.
- tick  input  1  1-cycle step strobe from the upstream counter; never held high more than 1 cycle.
- pause  input  1  level; 1 = ignore ticks, hold pattern.
- mode  input  2  requested mode: 0 ROT_L, 1 ROT_R, 2 PING, 3 BLINK.
- mode_vld  input  1  1-cycle strobe; captures `mode` as pending.
- led_out  output  LED_W  LED drive, active-high, registered.
- cur_mode  output  2  mode currently applied, registered.
- cycle_done  output  1  1-cycle pulse, one per full pattern period.

Behaviour:
- Reset, while sys_rst=1 at a sys_clk edge:
  - cur_mode=MODE_RST; led_out=start pattern of MODE_RST.
  - cycle_done=0; pending flag=0; ping-pong direction=up.
  - Reset has priority over every other input and aborts any pending mode change.
- Start patterns:
  - ROT_L: 0..01.
  - ROT_R: 10..0.
  - PING: 0..01, direction up.
  - BLINK: all 0.
- Mode capture: mode_vld=1 latches `mode` into pending_mode and sets pending. A later mode_vld before application overwrites it (last one wins).
- Effective tick: eff = tick & ~pause. Ticks arriving during pause are dropped, not queued.
- On eff with pending=1 (or mode_vld=1 in the same cycle, in which case the same-cycle value wins):
  - cur_mode <= new mode; led_out <= its start pattern.
  - Direction reset to up; pending cleared.
  - No step is taken on this tick, and cycle_done stays 0.
  - Applying the same mode as cur_mode still restarts the pattern.
- On eff with no pending change, step by cur_mode:
  - ROT_L: rotate left; MSB wraps to LSB. Period LED_W steps.
  - ROT_R: rotate right; LSB wraps to MSB. Period LED_W steps.
  - PING, direction up: shift left; when the new value has MSB set, direction <= down.
  - PING, direction down: shift right; when the new value has LSB set, direction <= up.
  - PING period is 2*(LED_W-1) steps; the end LEDs are lit exactly once per sweep, with no repeat at the turnaround.
  - BLINK: led_out <= ~led_out. Period 2 steps.
- cycle_done:
  - Asserted on the same edge where a stepping tick makes led_out equal the mode's start pattern (PING additionally requires direction=up).
  - Low on every other cycle, including mode loads and reset.
- Latency: led_out and cur_mode update on the sys_clk edge that samples eff=1, i.e. visible one cycle after tick is asserted.
- Between effective ticks, all outputs hold.
- pause does not block mode capture; a pending change applies at the first effective tick after pause falls.
- tick and pause are assumed synchronous to sys_clk; no internal synchronisers.

Test Plan (LED_W=4):
- Reset then 5 ticks in ROT_L:
  - After reset: led_out=0001, cur_mode=0.
  - After the ticks: led_out=0010,0100,1000,0001,0010.
  - cycle_done pulses once, with the 4th tick.
- mode=2, mode_vld=1, then 7 ticks:
  - 1st tick loads 0001 with cur_mode=2.
  - Subsequent ticks: 0010,0100,1000,0100,0010,0001.
  - cycle_done pulses on the 0001 step only.
- BLINK, pause, mode change:
  - mode=3 applied; 2 ticks give 1111 then 0000, with cycle_done on the 0000 step.
  - Raise pause and send 3 ticks: led_out holds 0000.
  - Send mode_vld=1 with mode=1 during pause, then drop pause: the next tick gives led_out=1000, cur_mode=1.
- mode_vld in the same cycle as tick:
  - mode_vld=1, mode=1, tick=1 from ROT_L state 0100: next cycle led_out=1000, cur_mode=1, cycle_done=0.
  - Two mode_vld strobes (mode=2 then mode=3) before a tick: mode 3 is applied.
- Reset mid-operation:
  - In PING direction=down at 0100 with a pending change to mode 1, assert sys_rst for 1 cycle coincident with tick.
  - Required: led_out=0001, cur_mode=0, cycle_done=0, pending discarded.
  - Next tick gives 0010.

Source files
------------

// File: rtl/led_flow_seq.sv
// led_flow_seq: steps a multi-LED pattern once per upstream tick.
// Four runtime-selectable patterns (rotate-left, rotate-right, ping-pong,
// blink-all), with pause, deferred mode switching and a once-per-period
// cycle_done strobe. All outputs are registered.
module led_flow_seq #(
  parameter int         LED_W    = 4,
  parameter logic [1:0] MODE_RST = 2'd0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic             mode_vld,
  output logic [LED_W-1:0] led_out,
  output logic [1:0]       cur_mode,
  output logic             cycle_done
);

  typedef enum logic [1:0] {
    ROT_L = 2'd0,
    ROT_R = 2'd1,
    PING  = 2'd2,
    BLINK = 2'd3
  } mode_t;

  mode_t      pending_mode;
  logic       pending;
  logic       dir_down;

  logic             eff;
  logic             apply;
  mode_t            new_mode;
  logic [LED_W-1:0] step_led;
  logic             step_dir_down;
  logic             step_done;

  // Pattern a mode starts from whenever it is (re)loaded.
  function automatic logic [LED_W-1:0] start_pat(input mode_t m);
    logic [LED_W-1:0] p;
    p = '0;
    case (m)
      ROT_L, PING: p[0]         = 1'b1;
      ROT_R:       p[LED_W-1]   = 1'b1;
      default:     p            = '0;
    endcase
    return p;
  endfunction

  // A paused tick is simply dropped; a same-cycle mode_vld beats the pending one.
  assign eff      = tick & ~pause;
  assign apply    = eff & (pending | mode_vld);
  assign new_mode = mode_vld ? mode_t'(mode) : pending_mode;

  // Next pattern value, ping-pong direction and period-complete flag for one step.
  always_comb begin
    step_led      = led_out;
    step_dir_down = dir_down;
    step_done     = 1'b0;
    case (mode_t'(cur_mode))
      ROT_L: begin
        step_led  = {led_out[LED_W-2:0], led_out[LED_W-1]};
        step_done = (step_led == start_pat(ROT_L));
      end
      ROT_R: begin
        step_led  = {led_out[0], led_out[LED_W-1:1]};
        step_done = (step_led == start_pat(ROT_R));
      end
      PING: begin
        // Turnaround happens on the step that lights an end LED, so ends are not repeated.
        if (!dir_down) begin
          step_led = led_out << 1;
          if (step_led[LED_W-1]) step_dir_down = 1'b1;
        end else begin
          step_led = led_out >> 1;
          if (step_led[0]) begin
            step_dir_down = 1'b0;
            step_done     = 1'b1;
          end
        end
      end
      default: begin
        step_led  = ~led_out;
        step_done = (step_led == start_pat(BLINK));
      end
    endcase
  end

  // Pattern, mode, direction and pending-change registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cur_mode   <= MODE_RST;
      led_out    <= start_pat(mode_t'(MODE_RST));
      cycle_done <= 1'b0;
      pending    <= 1'b0;
      dir_down   <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (apply) begin
        cur_mode <= new_mode;
        led_out  <= start_pat(new_mode);
        dir_down <= 1'b0;
        pending  <= 1'b0;
      end else begin
        if (eff) begin
          led_out    <= step_led;
          dir_down   <= step_dir_down;
          cycle_done <= step_done;
        end
        if (mode_vld) begin
          pending      <= 1'b1;
          pending_mode <= mode_t'(mode);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_flow_seq.sv
// tb_led_flow_seq: directed scenarios plus randomized traffic against a
// position-counter reference model of the LED pattern sequencer.
module tb_led_flow_seq;

  localparam int LED_W = 4;

  logic             sys_clk;
  logic             sys_rst;
  logic             tick;
  logic             pause;
  logic [1:0]       mode;
  logic             mode_vld;
  logic [LED_W-1:0] led_out;
  logic [1:0]       cur_mode;
  logic             cycle_done;

  int errors = 0;
  int checks = 0;

  // Reference model: mode plus step index within the mode's period.
  int   m_mode;
  int   m_k;
  bit   m_pend;
  int   m_pmode;
  logic exp_done;

  led_flow_seq #(.LED_W(LED_W), .MODE_RST(2'd0)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .tick       (tick),
    .pause      (pause),
    .mode       (mode),
    .mode_vld   (mode_vld),
    .led_out    (led_out),
    .cur_mode   (cur_mode),
    .cycle_done (cycle_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic int m_period(input int md);
    case (md)
      0, 1:    return LED_W;
      2:       return 2 * (LED_W - 1);
      default: return 2;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] m_pat(input int md, input int k);
    logic [LED_W-1:0] one;
    one = 1;
    case (md)
      0: return one << k;
      1: return one << (LED_W - 1 - k);
      2: return (k < LED_W) ? (one << k) : (one << (2 * (LED_W - 1) - k));
      default: return (k % 2 == 1) ? {LED_W{1'b1}} : '0;
    endcase
  endfunction

  // Drive one clock's worth of inputs, advance the model, settle past the edge.
  task automatic do_cycle(input bit r, input bit t, input bit p, input bit mv, input logic [1:0] m);
    bit eff;
    sys_rst = r; tick = t; pause = p; mode_vld = mv; mode = m;
    @(posedge sys_clk);
    exp_done = 1'b0;
    if (r) begin
      m_mode = 0; m_k = 0; m_pend = 0;
    end else begin
      eff = t && !p;
      if (eff && (m_pend || mv)) begin
        m_mode = mv ? int'(m) : m_pmode;
        m_k = 0; m_pend = 0;
      end else begin
        if (eff) begin
          m_k = (m_k + 1) % m_period(m_mode);
          exp_done = (m_k == 0);
        end
        if (mv) begin
          m_pend = 1; m_pmode = int'(m);
        end
      end
    end
    #1;
    sys_rst = 0; tick = 0; mode_vld = 0;
  endtask

  task automatic test_reset();
    do_cycle(0, 1, 0, 1, 2'd3);
    do_cycle(1, 0, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b0001) begin errors++; $display("FAIL reset_led got=%b want=0001", led_out); end
    checks++; if (cur_mode !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d want=0", cur_mode); end
    checks++; if (cycle_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", cycle_done); end
  endtask

  task automatic test_rot_l();
    logic [LED_W-1:0] tbl [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 1, 0, 0, 2'd0);
      checks++; if (led_out !== tbl[i]) begin errors++; $display("FAIL rotl_led[%0d] got=%b want=%b", i, led_out, tbl[i]); end
      checks++; if (cycle_done !== (i == 3)) begin errors++; $display("FAIL rotl_done[%0d] got=%b want=%b", i, cycle_done, (i == 3)); end
      do_cycle(0, 0, 0, 0, 2'd0);
      checks++; if (led_out !== tbl[i] || cycle_done !== 1'b0) begin errors++; $display("FAIL rotl_hold[%0d] got=%b/%b want=%b/0", i, led_out, cycle_done, tbl[i]); end
    end
  endtask

  task automatic test_ping();
    logic [LED_W-1:0] tbl [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_cycle(0, 0, 0, 1, 2'd2);
    checks++; if (cur_mode !== 2'd0) begin errors++; $display("FAIL ping_nodefer got=%0d want=0", cur_mode); end
    for (int i = 0; i < 7; i++) begin
      do_cycle(0, 1, 0, 0, 2'd0);
      checks++; if (led_out !== tbl[i]) begin errors++; $display("FAIL ping_led[%0d] got=%b want=%b", i, led_out, tbl[i]); end
      checks++; if (cycle_done !== (i == 6)) begin errors++; $display("FAIL ping_done[%0d] got=%b want=%b", i, cycle_done, (i == 6)); end
      do_cycle(0, 0, 0, 0, 2'd0);
    end
    checks++; if (cur_mode !== 2'd2) begin errors++; $display("FAIL ping_mode got=%0d want=2", cur_mode); end
  endtask

  task automatic test_blink_pause();
    do_cycle(0, 1, 0, 1, 2'd3);
    checks++; if (led_out !== 4'b0000 || cur_mode !== 2'd3) begin errors++; $display("FAIL blink_load got=%b/%0d want=0000/3", led_out, cur_mode); end
    do_cycle(0, 1, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b1111 || cycle_done !== 1'b0) begin errors++; $display("FAIL blink_on got=%b/%b want=1111/0", led_out, cycle_done); end
    do_cycle(0, 0, 0, 0, 2'd0);
    do_cycle(0, 1, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b0000 || cycle_done !== 1'b1) begin errors++; $display("FAIL blink_off got=%b/%b want=0000/1", led_out, cycle_done); end
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 0, 1, 0, 2'd0);
      do_cycle(0, 1, 1, 0, 2'd0);
      checks++; if (led_out !== 4'b0000 || cycle_done !== 1'b0) begin errors++; $display("FAIL pause_hold[%0d] got=%b/%b want=0000/0", i, led_out, cycle_done); end
    end
    do_cycle(0, 0, 1, 1, 2'd1);
    do_cycle(0, 1, 1, 0, 2'd0);
    checks++; if (cur_mode !== 2'd3) begin errors++; $display("FAIL pause_defer got=%0d want=3", cur_mode); end
    do_cycle(0, 0, 0, 0, 2'd0);
    do_cycle(0, 1, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b1000 || cur_mode !== 2'd1) begin errors++; $display("FAIL pause_apply got=%b/%0d want=1000/1", led_out, cur_mode); end
  endtask

  task automatic test_same_cycle();
    do_cycle(0, 1, 0, 1, 2'd0);
    do_cycle(0, 1, 0, 0, 2'd0);
    do_cycle(0, 1, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b0100 || cur_mode !== 2'd0) begin errors++; $display("FAIL same_setup got=%b/%0d want=0100/0", led_out, cur_mode); end
    do_cycle(0, 1, 0, 1, 2'd1);
    checks++; if (led_out !== 4'b1000 || cur_mode !== 2'd1 || cycle_done !== 1'b0) begin errors++; $display("FAIL same_apply got=%b/%0d/%b want=1000/1/0", led_out, cur_mode, cycle_done); end
    do_cycle(0, 0, 0, 1, 2'd2);
    do_cycle(0, 0, 0, 1, 2'd3);
    do_cycle(0, 1, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b0000 || cur_mode !== 2'd3) begin errors++; $display("FAIL last_wins got=%b/%0d want=0000/3", led_out, cur_mode); end
  endtask

  task automatic test_reset_mid();
    do_cycle(0, 1, 0, 1, 2'd2);
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b0100 || cur_mode !== 2'd2) begin errors++; $display("FAIL rmid_setup got=%b/%0d want=0100/2", led_out, cur_mode); end
    do_cycle(0, 0, 0, 1, 2'd1);
    do_cycle(1, 1, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b0001 || cur_mode !== 2'd0 || cycle_done !== 1'b0) begin errors++; $display("FAIL rmid_reset got=%b/%0d/%b want=0001/0/0", led_out, cur_mode, cycle_done); end
    do_cycle(0, 1, 0, 0, 2'd0);
    checks++; if (led_out !== 4'b0010 || cur_mode !== 2'd0) begin errors++; $display("FAIL rmid_next got=%b/%0d want=0010/0", led_out, cur_mode); end
  endtask

  task automatic test_random();
    bit last_t;
    bit r, t, p, mv;
    do_cycle(1, 0, 0, 0, 2'd0);
    last_t = 0;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      t  = !last_t && ($urandom_range(0, 1) == 1);
      p  = ($urandom_range(0, 4) == 0);
      mv = ($urandom_range(0, 9) == 0);
      do_cycle(r, t, p, mv, 2'($urandom_range(0, 3)));
      last_t = t;
      checks++;
      if (led_out !== m_pat(m_mode, m_k) || cur_mode !== 2'(m_mode) || cycle_done !== exp_done) begin
        errors++;
        $display("FAIL rand[%0d] got=%b/%0d/%b want=%b/%0d/%b", i, led_out, cur_mode, cycle_done,
                 m_pat(m_mode, m_k), m_mode, exp_done);
      end
    end
  endtask

  initial begin
    sys_rst = 1; tick = 0; pause = 0; mode = 0; mode_vld = 0;
    m_mode = 0; m_k = 0; m_pend = 0; m_pmode = 0; exp_done = 0;
    test_reset();
    test_rot_l();
    test_ping();
    test_blink_pause();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
